vedic_dot_accum: RTL

- Downstream stage of the 8x8 Vedic multiplier.
- Consumes the stream of 16-bit unsigned products it produces and accumulates them into a dot-product sum.
- Returns one result per vector: on an explicit last-term marker, or when the term count reaches MAX_TERMS.
- Valid/ready handshakes on both sides; the multiplier stays purely combinational upstream.

---
 rtl/vedic_pkg.sv | 13 +
 rtl/vedic_acc_add.sv | 27 ++
 rtl/vedic_dot_accum.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and types for the Vedic multiplier datapath.
package vedic_pkg;

  localparam int unsigned OPND_W    = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned ACC_W_DEF = 24;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/vedic_acc_add.sv
// Accumulator adder: ACC_W-bit add of a zero-extended product, with carry-out.
// With SAT_EN the result clamps to all-ones on carry. Once the accumulator
// sits at all-ones, every further non-zero add carries and re-clamps, so it
// stays saturated without separate sticky state.
module vedic_acc_add
  import vedic_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic              first,
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  // Start from zero on the first term of a vector, else from the running sum.
  always_comb begin
    full  = {1'b0, (first ? '0 : acc)} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry = full[ACC_W];
    sum   = (SAT_EN && carry) ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/vedic_dot_accum.sv
// Dot-product accumulator behind the 8x8 Vedic multiplier. Sums a stream of
// 16-bit products and emits one result per vector (on in_last or when the
// term count reaches MAX_TERMS), with valid/ready handshakes on both sides.
// Optional: define VEDIC_DOT_ACCUM_SAT_EN to saturate instead of wrapping.
module vedic_dot_accum
  import vedic_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned MAX_TERMS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_terms,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

`ifdef VEDIC_DOT_ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               first_q, first_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   terms_q, terms_d;
  logic               oovf_q, oovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;

  vedic_acc_add #(
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_add (
    .first (first_q),
    .acc   (acc_q),
    .prod  (in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Next-state: accept terms in ACCUM, latch the result on end of vector,
  // wait in HOLD until the consumer takes it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    sum_d   = sum_q;
    terms_d = terms_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d   = add_sum;
          cnt_d   = (first_q ? '0 : cnt_q) + CNT_W'(1);
          ovf_d   = (first_q ? 1'b0 : ovf_q) | add_carry;
          first_d = 1'b0;
          if (in_last || (cnt_d == MAX_CNT)) begin
            sum_d   = add_sum;
            terms_d = cnt_d;
            oovf_d  = ovf_d;
            state_d = HOLD;
            first_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      sum_q   <= '0;
      terms_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
      sum_q   <= sum_d;
      terms_q <= terms_d;
      oovf_q  <= oovf_d;
    end
  end

  // Handshake flags decode straight from the state.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_sum   = sum_q;
    out_terms = terms_q;
    out_ovf   = oovf_q;
  end

endmodule
